// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows the shared ALU for one add per RUN cycle.
// Optional early termination on an exhausted multiplier: define MUL_SEQUENCER_EARLY_EXIT_EN.
module mul_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic             alu_req_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_result_i
);

    localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]   step_acc;
    logic               last_step;

    // Accumulator value after this cycle's step; also the product on the final step.
    assign step_acc = mplier_q[0] ? alu_result_i : acc_q;

`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        alu_req_o  = 1'b0;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = 4'b0000;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d   = op_a_i;
                    mplier_d  = op_b_i;
                    acc_d     = '0;
                    cnt_d     = '0;
                    product_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                alu_req_o  = 1'b1;
                alu_a_o    = acc_q;
                alu_b_o    = mcand_q;
                alu_ctrl_o = ALU_ADD;
                acc_d      = step_acc;
                mcand_d    = mcand_q << 1;
                mplier_d   = mplier_q >> 1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (last_step) begin
                    product_d = step_acc;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign product_o = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: expected product and done cycle queued at start, checked on done.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] op_a = '0, op_b = '0;
    logic        busy, done, alu_req;
    logic [63:0] product, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    mul_sequencer #(.WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start), .op_a_i(op_a), .op_b_i(op_b),
        .busy_o(busy), .done_o(done), .product_o(product), .alu_req_o(alu_req),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .alu_result_i(alu_result)
    );

    // Shared ALU stand-in: only the add code produces a sum.
    assign alu_result = (alu_ctrl == 4'b0010) ? alu_a + alu_b : 64'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int exp_n(input logic [63:0] b);
        int n;
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
`else
        n = 64;
`endif
        return n;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_cnt++;
                if (product !== e.prod)
                    $display("FAIL product: got %h, expected %h", product, e.prod);
                else pass_cnt++;
                chk_cnt++;
                if (cyc !== e.cyc)
                    $display("FAIL done_cycle: got %0d, expected %0d", cyc, e.cyc);
                else pass_cnt++;
            end
        end
    end

    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        e.prod = a * b;
        e.cyc  = cyc + 1 + exp_n(b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (busy || sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL timeout_%s: busy=%b pending=%0d, expected idle with none pending", tag, busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({busy, done, alu_req, alu_ctrl} !== 7'b0 || product !== 64'h0 || alu_a !== 64'h0 || alu_b !== 64'h0)
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b ctrl=%h prod=%h a=%h b=%h, expected all 0",
                     busy, done, alu_req, alu_ctrl, product, alu_a, alu_b);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        launch(64'd3, 64'd5);
        chk_cnt++;
        if (alu_req !== 1'b1 || alu_ctrl !== 4'b0010 || alu_a !== 64'h0 || alu_b !== 64'd3)
            $display("FAIL run_step1: got req=%b ctrl=%h a=%h b=%h, expected 1 2 0 3", alu_req, alu_ctrl, alu_a, alu_b);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (alu_a !== 64'd3 || alu_b !== 64'd6)
            $display("FAIL run_step2: got a=%h b=%h, expected 3 6", alu_a, alu_b);
        else pass_cnt++;
        wait_idle("basic");
        chk_cnt++;
        if (alu_req !== 1'b0 || alu_ctrl !== 4'b0000 || product !== 64'd15)
            $display("FAIL idle_hold: got req=%b ctrl=%h prod=%h, expected 0 0 f", alu_req, alu_ctrl, product);
        else pass_cnt++;
    endtask

    task automatic test_patterns;
        int n = 0;
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_idle("allones");
        launch(-64'sd3, 64'd7);
        wait_idle("neg");
        launch(64'h1234, 64'd0);
        for (int i = 0; i < 200; i++) begin
            if (alu_req) n++;
            if (!busy) break;
            @(negedge clk);
        end
        chk_cnt++;
        if (n !== exp_n(64'd0)) $display("FAIL zero_run_cycles: got %0d, expected %0d", n, exp_n(64'd0));
        else pass_cnt++;
        wait_idle("zero");
    endtask

    task automatic test_start_ignored;
        int k, n;
        exp_t e;
        launch(64'd100, 64'd200);
        @(negedge clk);
        op_a = 64'd9; op_b = 64'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored");
        chk_cnt++;
        if (product !== 64'd20000) $display("FAIL start_in_run: got %h, expected %h", product, 64'd20000);
        else pass_cnt++;
        // start held through DONE must re-accept at the first IDLE edge
        @(negedge clk);
        op_a = 64'd6; op_b = 64'd7; start = 1'b1;
        k = cyc + 1;
        n = exp_n(64'd7);
        e.prod = 64'd42; e.cyc = k + n;         sb.push_back(e);
        e.prod = 64'd42; e.cyc = k + n + 2 + n; sb.push_back(e);
        while (cyc < k + n + 2) @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1 || alu_req !== 1'b1) $display("FAIL held_start: got busy=%b req=%b, expected 1 1", busy, alu_req);
        else pass_cnt++;
        wait_idle("held");
    endtask

    task automatic test_reset_mid_run;
        launch(64'd5, 64'd7);
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || alu_req !== 1'b0 || product !== 64'h0 || done !== 1'b0 || alu_a !== 64'h0)
            $display("FAIL async_reset: got busy=%b req=%b prod=%h done=%b a=%h, expected all 0",
                     busy, alu_req, product, done, alu_a);
        else pass_cnt++;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || product !== 64'h0) $display("FAIL post_reset: got busy=%b prod=%h, expected 0 0", busy, product);
        else pass_cnt++;
        launch(64'd11, 64'd13);
        wait_idle("after_reset");
    endtask

    task automatic test_random;
        logic [63:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            launch(a, b);
            wait_idle("random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_patterns;
        test_start_ignored;
        test_reset_mid_run;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
